prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_asm.sv | 47 ++++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, word geometry and
// checksum width. The optional checksum stage is enabled by defining
// PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int CSUM_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake carrying program bytes into the loader.
// A byte moves only in a cycle where byte_valid and byte_ready are both high.
interface prog_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/prog_loader_asm.sv
// Little-endian byte-to-word assembler. Byte n of a word lands in bits
// [8n+7:8n]; word_o already includes the byte being accepted this cycle so
// the parent can capture a complete word on the fourth transfer.
module prog_loader_asm
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = BYTES_PER_WORD * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              fire_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              lastByte_o
);

    logic [BYTE_IDX_W-1:0] byteIdx_q, byteIdx_d;
    logic [DATA_W-1:0]     word_q, word_d;

    // Place the incoming byte into its lane and advance the byte index
    always_comb begin
        byteIdx_d = byteIdx_q;
        word_d    = word_q;
        if (clear_i) begin
            byteIdx_d = '0;
        end else if (fire_i) begin
            word_d[byteIdx_q*8 +: 8] = byte_i;
            byteIdx_d                = byteIdx_q + 1'b1;
        end
    end

    // Hold the partially assembled word and the byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            byteIdx_q <= '0;
            word_q    <= '0;
        end else begin
            byteIdx_q <= byteIdx_d;
            word_q    <= word_d;
        end
    end

    assign word_o     = word_d;
    assign lastByte_o = (byteIdx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream, writes 32-bit words into the
// instruction memory, and releases the CPU once the program is in place.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte that
// must match the modulo-256 sum of all program bytes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_len_i,
    prog_loader_if.slave      byteIf,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_run_o,
    output logic              load_err_o
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] lenLast_q;
    logic [ADDR_W-1:0] wordAddr_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;

    logic              byteFire;
    logic              loadFire;
    logic              startLoad;
    logic              lastByte;
    logic              lastWord;
    logic              wordFull;
    logic [DATA_W-1:0] asmWord;

    assign byteFire  = byteIf.byte_valid && byteIf.byte_ready;
    assign loadFire  = byteFire && (state_q == LOAD);
    assign startLoad = load_start_i &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign lastWord  = (wordAddr_q == lenLast_q);
    assign wordFull  = loadFire && lastByte;

    prog_loader_asm #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (startLoad),
        .fire_i    (loadFire),
        .byte_i    (byteIf.byte_data),
        .word_o    (asmWord),
        .lastByte_o(lastByte)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] checksum_q;

    // Running modulo-256 sum of every program byte accepted during LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (startLoad) begin
            checksum_q <= '0;
        end else if (loadFire) begin
            checksum_q <= checksum_q + byteIf.byte_data;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a length of 0 yields an all-ones last address
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (load_start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (wordFull && lastWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (byteFire) begin
                    state_d = (byteIf.byte_data == checksum_q) ? DONE : ERROR;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        byteIf.byte_ready = (state_q == LOAD) || (state_q == CHECK);
        cpu_run_o         = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
        load_err_o        = (state_q == ERROR);
`else
        load_err_o        = 1'b0;
`endif
    end

    // Word address, latched length and the registered memory write port
    always_ff @(posedge clk) begin
        if (rst) begin
            lenLast_q  <= '0;
            wordAddr_q <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            memWe_q <= wordFull;
            if (startLoad) begin
                wordAddr_q <= '0;
                lenLast_q  <= load_len_i - ADDR_W'(1);
            end else if (wordFull) begin
                memAddr_q  <= wordAddr_q;
                memWdata_q <= asmWord;
                if (!lastWord) begin
                    wordAddr_q <= wordAddr_q + 1'b1;
                end
            end
        end
    end

    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader. Expected memory writes are queued as
// words are sent; a negedge monitor pops and compares on every mem_we.
// Checksum-specific sequences follow PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start_i;
    logic [ADDR_W-1:0] load_len_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              cpu_run_o;
    logic              load_err_o;

    wr_t expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;

    prog_loader_if byteIf ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start_i(load_start_i),
        .load_len_i  (load_len_i),
        .byteIf      (byteIf),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_run_o   (cpu_run_o),
        .load_err_o  (load_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation
    always @(negedge clk) begin
        wr_t e;
        if (mem_we_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_write addr=%h data=%h required=no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_addr", 32'(mem_addr_o), 32'(e.addr));
                checkOutput("wr_data", mem_wdata_o, e.data);
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic startLoad(input logic [ADDR_W-1:0] len);
        load_start_i = 1'b1;
        load_len_i   = len;
        idleCycles(1);
        load_start_i = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        byteIf.byte_valid = 1'b1;
        byteIf.byte_data  = b;
        @(negedge clk);
        while (byteIf.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkCount++;
            $display("[TB] FAIL byte_accept_timeout ready=%b required=1", byteIf.byte_ready);
        end
        @(posedge clk);
        #1;
        byteIf.byte_valid = 1'b0;
        if (gap) idleCycles(1);
    endtask

    task automatic sendWord(input logic [ADDR_W-1:0] addr, input logic [31:0] word,
                            input bit gap);
        wr_t e;
        e.addr = addr;
        e.data = word;
        expQ.push_back(e);
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            sendByte(word[i*8 +: 8], gap);
        end
    endtask

    task automatic checkEnd(input string tag, input logic run, input logic err);
        idleCycles(3);
        checkOutput({tag, "_queue_empty"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "_cpu_run"}, 32'(cpu_run_o), 32'(run));
        checkOutput({tag, "_load_err"}, 32'(load_err_o), 32'(err));
        checkOutput({tag, "_byte_ready"}, 32'(byteIf.byte_ready), 32'd0);
    endtask

    task automatic applyStimulus();
        logic [31:0] w;

        // Reset state
        rst = 1'b1; load_start_i = 1'b0; load_len_i = '0;
        byteIf.byte_valid = 1'b0; byteIf.byte_data = '0;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("rst_byte_ready", 32'(byteIf.byte_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_cpu_run", 32'(cpu_run_o), 32'd0);
        checkOutput("rst_load_err", 32'(load_err_o), 32'd0);

        // Single-word load
        startLoad(7'd1);
        checkOutput("load_byte_ready", 32'(byteIf.byte_ready), 32'd1);
        sendWord(7'd0, 32'h0000_0013, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(8'h13, 1'b0);
`endif
        checkEnd("one", 1'b1, 1'b0);
        checkOutput("one_hold_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("one_hold_data", mem_wdata_o, 32'h0000_0013);

        // Two words with byte_valid toggling every other cycle
        startLoad(7'd2);
        checkOutput("two_cpu_run_cleared", 32'(cpu_run_o), 32'd0);
        sendWord(7'd0, 32'h0403_0201, 1'b1);
        sendWord(7'd1, 32'h0807_0605, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(8'h24, 1'b1);
`endif
        checkEnd("two", 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum goes to ERROR, then a correct retry reaches DONE
        startLoad(7'd1);
        sendWord(7'd0, 32'h0000_FFFF, 1'b0);
        sendByte(8'hFF, 1'b0);
        checkEnd("bad_csum", 1'b0, 1'b1);
        startLoad(7'd1);
        checkOutput("retry_err_cleared", 32'(load_err_o), 32'd0);
        sendWord(7'd0, 32'h0000_FFFF, 1'b0);
        sendByte(8'hFE, 1'b0);
        checkEnd("good_csum", 1'b1, 1'b0);
`endif

        // Reset mid-word abandons the partial word; rst beats load_start
        startLoad(7'd1);
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        rst = 1'b1;
        load_start_i = 1'b1;
        load_len_i = 7'd1;
        idleCycles(1);
        rst = 1'b0;
        load_start_i = 1'b0;
        idleCycles(1);
        checkOutput("midrst_byte_ready", 32'(byteIf.byte_ready), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("midrst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("midrst_cpu_run", 32'(cpu_run_o), 32'd0);
        startLoad(7'd1);
        sendWord(7'd0, 32'h4433_2211, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(8'hAA, 1'b0);
`endif
        checkEnd("after_rst", 1'b1, 1'b0);

        // Full memory: length 0 means 128 words; load_start mid-load ignored
        startLoad(7'd0);
        for (int k = 0; k < 128; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            if (k == 10) begin
                load_start_i = 1'b1;
                load_len_i   = 7'd3;
            end
            sendWord(7'(k), w, 1'b0);
            load_start_i = 1'b0;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(8'h00, 1'b0);
`endif
        checkEnd("full", 1'b1, 1'b0);
        checkOutput("full_last_addr", 32'(mem_addr_o), 32'd127);
        checkOutput("full_last_data", mem_wdata_o, 32'hFFFE_FDFC);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
